// File: rtl/cc_miss_req_unit.sv
// Cache-controller miss request stage: pushes the miss address to the fill FIFO and
// issues one 8x64-bit AXI read burst per miss. Optional build macro: CC_CRITICAL_WORD_FIRST_EN.
module cc_miss_req_unit #(
  parameter int       MAX_OUTSTANDING = 2,
  parameter logic [3:0] AR_ID         = 4'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        miss_valid_i,
  input  logic [31:0] miss_addr_i,
  output logic        miss_ready_o,
  input  logic        miss_addr_fifo_full_i,
  output logic        miss_addr_fifo_wren_o,
  output logic [31:0] miss_addr_fifo_wdata_o,
  output logic [3:0]  mem_arid_o,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  input  logic        mem_rvalid_i,
  input  logic        mem_rready_i,
  input  logic        mem_rlast_i,
  output logic        busy_o
);

  localparam int CW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [CW-1:0] MAX_CNT = CW'(MAX_OUTSTANDING);

  typedef enum logic {S_IDLE, S_AR} state_e;

  state_e        state_q, state_d;
  logic          arvalid_q, arvalid_d;
  logic [31:0]   araddr_q, araddr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic        accept;
  logic        ar_hs;
  logic        retire;
  logic [31:0] burst_addr;

`ifdef CC_CRITICAL_WORD_FIRST_EN
  // WRAP burst from the requested 8-byte word so it returns first.
  assign burst_addr    = {miss_addr_i[31:3], 3'b0};
  assign mem_arburst_o = 2'b10;
`else
  assign burst_addr    = {miss_addr_i[31:6], 6'b0};
  assign mem_arburst_o = 2'b01;
`endif

  assign miss_ready_o = (state_q == S_IDLE) && !miss_addr_fifo_full_i && (cnt_q < MAX_CNT);
  assign accept       = miss_valid_i & miss_ready_o;
  assign ar_hs        = arvalid_q & mem_arready_i;
  assign retire       = mem_rvalid_i & mem_rready_i & mem_rlast_i;

  assign miss_addr_fifo_wren_o  = accept;
  assign miss_addr_fifo_wdata_o = miss_addr_i;

  assign mem_arid_o    = AR_ID;
  assign mem_arlen_o   = 4'd7;
  assign mem_arsize_o  = 3'd3;
  assign mem_arvalid_o = arvalid_q;
  assign mem_araddr_o  = araddr_q;
  assign busy_o        = (state_q != S_IDLE) || (cnt_q != '0);

  always_comb begin
    state_d   = state_q;
    arvalid_d = arvalid_q;
    araddr_d  = araddr_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          state_d   = S_AR;
          arvalid_d = 1'b1;
          araddr_d  = burst_addr;
        end
      end
      S_AR: begin
        if (mem_arready_i) begin
          state_d   = S_IDLE;
          arvalid_d = 1'b0;
        end
      end
      default: begin
        state_d   = S_IDLE;
        arvalid_d = 1'b0;
      end
    endcase
  end

  // A retire at zero is dropped, so a coincident handshake still counts up.
  always_comb begin
    cnt_d = cnt_q;
    if (ar_hs && !(retire && cnt_q != '0))
      cnt_d = cnt_q + CW'(1);
    else if (!ar_hs && retire && cnt_q != '0)
      cnt_d = cnt_q - CW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      arvalid_q <= 1'b0;
      araddr_q  <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      arvalid_q <= arvalid_d;
      araddr_q  <= araddr_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule
